// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the RV32I pipeline hazard
//               controller: FSM state encoding, the x0 register index and the
//               performance-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Hazard controller FSM states (value visible on o_state)
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDUSE   = 2'd1,
        ST_MEMWAIT = 2'd2
    } hz_state_e;

    // Architectural zero register, never a real data dependency
    localparam logic [4:0] REG_X0 = 5'd0;

    // Width of the stall/flush performance counters
    localparam int CNT_W = 32;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_lu_cmp.sv
`default_nettype none
// ============================================================================
// Module      : hazard_lu_cmp
// Description : Combinational load-use hazard detector. Flags when the load
//               in EX writes a register that the ID instruction actually
//               reads. A load to x0 never creates a hazard.
// Ports       : i_id_rs1_addr/i_id_rs2_addr - ID source register indices
//               i_id_rs1_used/i_id_rs2_used - ID instruction reads rs1/rs2
//               i_ex_rd_addr                - EX destination register
//               i_ex_rd_wren                - EX instruction writes rd
//               i_ex_mem_rden               - EX instruction is a load
//               o_lu                        - load-use hazard present
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_lu_cmp
    import hazard_pkg::*;
(
    input  logic [4:0] i_id_rs1_addr,
    input  logic [4:0] i_id_rs2_addr,
    input  logic       i_id_rs1_used,
    input  logic       i_id_rs2_used,
    input  logic [4:0] i_ex_rd_addr,
    input  logic       i_ex_rd_wren,
    input  logic       i_ex_mem_rden,
    output logic       o_lu
);

    logic w_ex_load_wr;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // A load only matters if it really lands in a non-zero register
    assign w_ex_load_wr = i_ex_mem_rden & i_ex_rd_wren & (i_ex_rd_addr != REG_X0);

    // Unused source fields may hold garbage encodings, so gate by the used bits
    assign w_rs1_hit = i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr);
    assign w_rs2_hit = i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr);

    assign o_lu = w_ex_load_wr & (w_rs1_hit | w_rs2_hit);

endmodule : hazard_lu_cmp
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for the 5-stage RV32I core.
//               Generates PC stall and per-stage pipeline-register stall and
//               flush controls for load-use hazards, EX-stage redirects and
//               data-memory busy freezes. Controls are Mealy (same-cycle).
//               Also keeps stall/flush performance counters and a sticky
//               data-memory busy timeout flag.
// Ports       : i_clk, i_rst        - clock, synchronous active-high reset
//               i_id_*              - ID-stage source registers / used bits
//               i_ex_*              - EX-stage rd, write enable, load, redirect
//               i_lsu_busy          - DMEM not ready for the MEM-stage access
//               o_pc_stall          - hold PC
//               o_ifid_stall/flush  - hold / bubble IF/ID
//               o_idex_stall/flush  - hold / bubble ID/EX
//               o_exmem_stall       - hold EX/MEM
//               o_memwb_flush       - bubble into MEM/WB
//               o_stall_cnt         - cycles with o_pc_stall asserted
//               o_flush_cnt         - redirect flush events
//               o_mem_timeout       - sticky busy-timeout error
//               o_state             - FSM state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_ex_rd_addr,
    input  logic             i_ex_rd_wren,
    input  logic             i_ex_mem_rden,
    input  logic             i_ex_redirect,
    input  logic             i_lsu_busy,
    output logic             o_pc_stall,
    output logic             o_ifid_stall,
    output logic             o_ifid_flush,
    output logic             o_idex_stall,
    output logic             o_idex_flush,
    output logic             o_exmem_stall,
    output logic             o_memwb_flush,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic             o_mem_timeout,
    output logic [1:0]       o_state
);

    localparam int                  c_BUSY_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_BUSY_W-1:0] c_BUSY_MAX = c_BUSY_W'(MEM_TIMEOUT);
    // The first bubble is taken in RUN, the remaining LOAD_LAT-1 in LDUSE
    localparam logic [1:0]          c_BUB_INIT = 2'(LOAD_LAT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    hz_state_e           r_state;
    hz_state_e           r_ret_state;
    logic [1:0]          r_bub_cnt;
    logic [c_BUSY_W-1:0] r_busy_cnt;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;
    logic                r_mem_timeout;

    // ------------------------------------------------------------------
    // Combinational controls and next-state
    // ------------------------------------------------------------------
    hz_state_e           w_eval_state;
    hz_state_e           w_state_nxt;
    hz_state_e           w_ret_nxt;
    logic [1:0]          w_bub_nxt;
    logic [c_BUSY_W-1:0] w_busy_nxt;
    logic                w_redir_evt;
    logic                w_lu;
    logic                w_pc_stall;
    logic                w_ifid_stall;
    logic                w_ifid_flush;
    logic                w_idex_stall;
    logic                w_idex_flush;
    logic                w_exmem_stall;
    logic                w_memwb_flush;

    hazard_lu_cmp u_lu_cmp (
        .i_id_rs1_addr (i_id_rs1_addr),
        .i_id_rs2_addr (i_id_rs2_addr),
        .i_id_rs1_used (i_id_rs1_used),
        .i_id_rs2_used (i_id_rs2_used),
        .i_ex_rd_addr  (i_ex_rd_addr),
        .i_ex_rd_wren  (i_ex_rd_wren),
        .i_ex_mem_rden (i_ex_mem_rden),
        .o_lu          (w_lu)
    );

    // Once the memory port frees up, the held cycle is judged by the rules of
    // the state that was interrupted, so the redirect or load still sitting in
    // EX is acted on in that same cycle.
    assign w_eval_state = (r_state == ST_MEMWAIT) ? r_ret_state : r_state;

    always_comb begin
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_stall  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_stall = 1'b0;
        w_memwb_flush = 1'b0;
        w_redir_evt   = 1'b0;
        w_state_nxt   = r_state;
        w_ret_nxt     = r_ret_state;
        w_bub_nxt     = r_bub_cnt;

        if (i_rst) begin
            // Fill the pipe with bubbles while reset is held
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_memwb_flush = 1'b1;
            w_state_nxt   = ST_RUN;
            w_ret_nxt     = ST_RUN;
            w_bub_nxt     = 2'd0;
        end else if (i_lsu_busy) begin
            // Freeze everything upstream of MEM; MEM/WB gets a bubble because
            // the MEM-stage access has not completed. Redirects are ignored
            // here: EX is held, so the redirect is seen again on exit.
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
            w_idex_stall  = 1'b1;
            w_exmem_stall = 1'b1;
            w_memwb_flush = 1'b1;
            w_state_nxt   = ST_MEMWAIT;
            w_ret_nxt     = w_eval_state;
        end else begin
            case (w_eval_state)
                ST_LDUSE: begin
                    w_pc_stall   = 1'b1;
                    w_ifid_stall = 1'b1;
                    w_idex_flush = 1'b1;
                    if (r_bub_cnt <= 2'd1) begin
                        w_bub_nxt   = 2'd0;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_bub_nxt   = r_bub_cnt - 2'd1;
                        w_state_nxt = ST_LDUSE;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    w_ret_nxt   = ST_RUN;
                    if (i_ex_redirect) begin
                        // Redirect beats load-use: the dependent ID
                        // instruction is on the wrong path and gets flushed.
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                        w_redir_evt  = 1'b1;
                    end else if (w_lu) begin
                        w_pc_stall   = 1'b1;
                        w_ifid_stall = 1'b1;
                        w_idex_flush = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_bub_nxt   = c_BUB_INIT;
                            w_state_nxt = ST_LDUSE;
                        end
                    end
                end
            endcase
        end
    end

    // Consecutive busy cycles, saturating at the timeout threshold
    always_comb begin
        w_busy_nxt = '0;
        if (i_lsu_busy) begin
            w_busy_nxt = (r_busy_cnt == c_BUSY_MAX) ? r_busy_cnt : r_busy_cnt + c_BUSY_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_RUN;
            r_ret_state   <= ST_RUN;
            r_bub_cnt     <= 2'd0;
            r_busy_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret_state <= w_ret_nxt;
            r_bub_cnt   <= w_bub_nxt;
            r_busy_cnt  <= w_busy_nxt;
            r_stall_cnt <= r_stall_cnt + CNT_W'(w_pc_stall);
            r_flush_cnt <= r_flush_cnt + CNT_W'(w_redir_evt);
            if (w_busy_nxt == c_BUSY_MAX) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: a flush always overrides a stall on the same register
    // ------------------------------------------------------------------
    assign o_pc_stall    = w_pc_stall;
    assign o_ifid_stall  = w_ifid_stall & ~w_ifid_flush;
    assign o_ifid_flush  = w_ifid_flush;
    assign o_idex_stall  = w_idex_stall & ~w_idex_flush;
    assign o_idex_flush  = w_idex_flush;
    assign o_exmem_stall = w_exmem_stall;
    assign o_memwb_flush = w_memwb_flush;
    assign o_stall_cnt   = r_stall_cnt;
    assign o_flush_cnt   = r_flush_cnt;
    assign o_mem_timeout = r_mem_timeout;
    assign o_state       = r_state;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Three instances share
//               one stimulus stream (LOAD_LAT = 1, 2, 3; MEM_TIMEOUT = 16).
//               Per-cycle expected controls are queued when a cycle is
//               driven and compared once the outputs have settled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    // Control vector: {pc_stall, ifid_stall, ifid_flush, idex_stall,
    //                  idex_flush, exmem_stall, memwb_flush}
    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [6:0] C_FRZ  = 7'b1101011;
    localparam logic [6:0] C_RDR  = 7'b0010100;
    localparam logic [6:0] C_RST  = 7'b0010101;
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_LDU  = 2'd1;
    localparam logic [1:0] S_MW   = 2'd2;

    typedef struct packed {
        logic       rst;
        logic       busy;
        logic       redir;
        logic       ld;
        logic [4:0] rd;
        logic       u1;
        logic [4:0] rs1;
        logic       u2;
        logic [4:0] rs2;
    } stim_t;

    typedef struct {
        int         d;
        logic [8:0] exp;
        string      tag;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic        id_u1 = 1'b0;
    logic        id_u2 = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_wren = 1'b0;
    logic        ex_rden = 1'b0;
    logic        ex_redir = 1'b0;
    logic        lsu_busy = 1'b0;

    logic        pc_stall    [3];
    logic        ifid_stall  [3];
    logic        ifid_flush  [3];
    logic        idex_stall  [3];
    logic        idex_flush  [3];
    logic        exmem_stall [3];
    logic        memwb_flush [3];
    logic [31:0] stall_cnt   [3];
    logic [31:0] flush_cnt   [3];
    logic        mem_tmo     [3];
    logic [1:0]  st          [3];

    int  n_chk  = 0;
    int  n_fail = 0;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        hazard_ctrl #(
            .LOAD_LAT    (gi + 1),
            .MEM_TIMEOUT (16)
        ) u_dut (
            .i_clk         (clk),
            .i_rst         (rst),
            .i_id_rs1_addr (id_rs1),
            .i_id_rs2_addr (id_rs2),
            .i_id_rs1_used (id_u1),
            .i_id_rs2_used (id_u2),
            .i_ex_rd_addr  (ex_rd),
            .i_ex_rd_wren  (ex_wren),
            .i_ex_mem_rden (ex_rden),
            .i_ex_redirect (ex_redir),
            .i_lsu_busy    (lsu_busy),
            .o_pc_stall    (pc_stall[gi]),
            .o_ifid_stall  (ifid_stall[gi]),
            .o_ifid_flush  (ifid_flush[gi]),
            .o_idex_stall  (idex_stall[gi]),
            .o_idex_flush  (idex_flush[gi]),
            .o_exmem_stall (exmem_stall[gi]),
            .o_memwb_flush (memwb_flush[gi]),
            .o_stall_cnt   (stall_cnt[gi]),
            .o_flush_cnt   (flush_cnt[gi]),
            .o_mem_timeout (mem_tmo[gi]),
            .o_state       (st[gi])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic stim_t mk(input logic r, input logic b, input logic rd_ir,
                                 input logic l, input logic [4:0] rd,
                                 input logic u1, input logic [4:0] rs1,
                                 input logic u2, input logic [4:0] rs2);
        stim_t s;
        s.rst = r; s.busy = b; s.redir = rd_ir; s.ld = l; s.rd = rd;
        s.u1 = u1; s.rs1 = rs1; s.u2 = u2; s.rs2 = rs2;
        return s;
    endfunction

    function automatic logic [8:0] dut_obs(input int d);
        return {pc_stall[d], ifid_stall[d], ifid_flush[d], idex_stall[d],
                idex_flush[d], exmem_stall[d], memwb_flush[d], st[d]};
    endfunction

    task automatic apply(input stim_t s);
        rst      = s.rst;
        lsu_busy = s.busy;
        ex_redir = s.redir;
        ex_rden  = s.ld;
        ex_wren  = s.ld;
        ex_rd    = s.rd;
        id_u1    = s.u1;
        id_rs1   = s.rs1;
        id_u2    = s.u2;
        id_rs2   = s.rs2;
    endtask

    // One clock cycle: drive, queue the expected controls, compare after settle
    task automatic cyc(input int d, input stim_t s, input logic [6:0] ectl,
                       input logic [1:0] est, input string tag);
        sb_t e;
        @(negedge clk);
        apply(s);
        e.d = d; e.exp = {ectl, est}; e.tag = tag;
        sb_q.push_back(e);
        #2;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, 64'(dut_obs(e.d)), 64'(e.exp));
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst(input int d, input stim_t rs);
        @(negedge clk);
        apply(rs);
        cyc(d, rs, C_RST, S_RUN, "rst_hold");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s_nop, s_rst, s_lu, s_busy, s_rdr, s_rdr_lu;
        s_nop    = mk(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        s_rst    = mk(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        s_lu     = mk(0, 0, 0, 1, 5'd5, 1, 5'd5, 1, 5'd1);  // lw x5 ; add x6,x5,x1
        s_busy   = mk(0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        s_rdr    = mk(0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        s_rdr_lu = mk(0, 0, 1, 1, 5'd5, 1, 5'd5, 1, 5'd1);

        // Reset state
        cyc(0, s_rst, C_RST, S_RUN, "rst_ctl");
        after_edge();
        chk("rst_stall_cnt", 64'(stall_cnt[0]), 64'd0);
        chk("rst_flush_cnt", 64'(flush_cnt[0]), 64'd0);
        chk("rst_tmo", 64'(mem_tmo[0]), 64'd0);

        // LOAD_LAT=1 load-use on rs1: single bubble
        cyc(0, s_lu, C_LU, S_RUN, "lu1_stall");
        cyc(0, s_nop, C_IDLE, S_RUN, "lu1_done");
        after_edge();
        chk("lu1_stall_cnt", 64'(stall_cnt[0]), 64'd1);

        // No hazard cases, then an rs2 hazard
        cyc(0, mk(0, 0, 0, 1, 5'd0, 1, 5'd0, 0, 5'd0), C_IDLE, S_RUN, "lu_x0");
        cyc(0, mk(0, 0, 0, 1, 5'd5, 1, 5'd1, 0, 5'd5), C_IDLE, S_RUN, "lu_rs2_unused");
        cyc(0, mk(0, 0, 0, 0, 5'd5, 1, 5'd5, 1, 5'd1), C_IDLE, S_RUN, "lu_not_load");
        cyc(0, mk(0, 0, 0, 1, 5'd5, 1, 5'd1, 1, 5'd5), C_LU, S_RUN, "lu_rs2_hit");
        cyc(0, s_nop, C_IDLE, S_RUN, "lu_rs2_done");
        after_edge();
        chk("lu_rs2_stall_cnt", 64'(stall_cnt[0]), 64'd2);

        // LOAD_LAT=2: two bubbles, one cycle in LDUSE
        do_rst(1, s_rst);
        cyc(1, s_lu, C_LU, S_RUN, "lu2_a");
        cyc(1, s_nop, C_LU, S_LDU, "lu2_b");
        cyc(1, s_nop, C_IDLE, S_RUN, "lu2_done");
        after_edge();
        chk("lu2_stall_cnt", 64'(stall_cnt[1]), 64'd2);

        // Redirect alone and redirect together with a load-use
        do_rst(0, s_rst);
        cyc(0, s_rdr, C_RDR, S_RUN, "redir");
        cyc(0, s_nop, C_IDLE, S_RUN, "redir_done");
        after_edge();
        chk("redir_flush_cnt", 64'(flush_cnt[0]), 64'd1);
        cyc(0, s_rdr_lu, C_RDR, S_RUN, "redir_lu");
        cyc(0, s_nop, C_IDLE, S_RUN, "redir_lu_done");
        after_edge();
        chk("redir_lu_flush_cnt", 64'(flush_cnt[0]), 64'd2);
        chk("redir_lu_stall_cnt", 64'(stall_cnt[0]), 64'd0);

        // LOAD_LAT=3 with a 5-cycle busy stretch inside LDUSE
        do_rst(2, s_rst);
        cyc(2, s_lu, C_LU, S_RUN, "lu3_first");
        for (int i = 0; i < 5; i++) begin
            stim_t sb;
            sb = s_busy;
            sb.redir = (i == 2);
            cyc(2, sb, C_FRZ, (i == 0) ? S_LDU : S_MW, $sformatf("lu3_frz%0d", i));
        end
        cyc(2, s_nop, C_LU, S_MW, "lu3_resume");
        cyc(2, s_nop, C_LU, S_LDU, "lu3_last");
        cyc(2, s_nop, C_IDLE, S_RUN, "lu3_done");
        after_edge();
        chk("lu3_stall_cnt", 64'(stall_cnt[2]), 64'd8);
        chk("lu3_flush_cnt", 64'(flush_cnt[2]), 64'd0);

        // Reset in the middle of LDUSE leaves no residual bubble
        cyc(2, s_lu, C_LU, S_RUN, "rst_ldu_a");
        cyc(2, s_rst, C_RST, S_LDU, "rst_ldu_b");
        cyc(2, s_nop, C_IDLE, S_RUN, "rst_ldu_after");

        // Busy timeout: 16 consecutive busy cycles
        do_rst(0, s_rst);
        for (int i = 0; i < 16; i++) begin
            cyc(0, s_busy, C_FRZ, (i == 0) ? S_RUN : S_MW, $sformatf("tmo_frz%0d", i));
            if (i == 14) begin
                after_edge();
                chk("tmo_before", 64'(mem_tmo[0]), 64'd0);
            end
        end
        after_edge();
        chk("tmo_set", 64'(mem_tmo[0]), 64'd1);
        cyc(0, s_nop, C_IDLE, S_MW, "tmo_exit");
        after_edge();
        chk("tmo_sticky", 64'(mem_tmo[0]), 64'd1);
        chk("tmo_stall_cnt", 64'(stall_cnt[0]), 64'd16);
        chk("tmo_state_run", 64'(st[0]), 64'(S_RUN));
        cyc(0, s_rst, C_RST, S_RUN, "tmo_rst");
        after_edge();
        chk("tmo_cleared", 64'(mem_tmo[0]), 64'd0);
        chk("tmo_rst_stall_cnt", 64'(stall_cnt[0]), 64'd0);

        // Reset while frozen returns straight to RUN
        cyc(0, s_busy, C_FRZ, S_RUN, "rst_mw_a");
        cyc(0, s_rst, C_RST, S_MW, "rst_mw_b");
        cyc(0, s_nop, C_IDLE, S_RUN, "rst_mw_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
